// File: rtl/stream_mux_rr_if.sv
// Stream bundle for stream_mux_rr: N_CH producer channels merged into one registered output.
// in_last/out_last exist only when STREAM_MUX_PKT_LOCK_EN is defined.
interface stream_mux_rr_if #(
   parameter int N_CH = 4,
   parameter int W    = 8
);
   localparam int CH_W = $clog2(N_CH);

   logic [N_CH-1:0]   in_valid;
   logic [N_CH*W-1:0] in_data;
   logic [N_CH-1:0]   in_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [CH_W-1:0]   out_ch;
   logic              out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
   logic [N_CH-1:0]   in_last;
   logic              out_last;
`endif

   // Environment side: producers plus the downstream consumer.
   modport master (
      output in_valid, in_data, out_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
      output in_last,
      input  out_last,
`endif
      input  in_ready, out_valid, out_data, out_ch
   );

   // Multiplexer side.
   modport slave (
      input  in_valid, in_data, out_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
      input  in_last,
      output out_last,
`endif
      output in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/stream_mux_rr.sv
// N_CH-channel round-robin stream multiplexer with one registered output stage.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_rr #(
   parameter int N_CH = 4,
   parameter int W    = 8
) (
   input logic           clk,
   input logic           rst_n,
   stream_mux_rr_if.slave bus
);
   localparam int CH_W = $clog2(N_CH);

   logic [CH_W-1:0] ptr_q, ptr_d;
   logic            out_valid_q, out_valid_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic [CH_W-1:0] out_ch_q, out_ch_d;

`ifdef STREAM_MUX_PKT_LOCK_EN
   typedef enum logic {ARB_FREE, ARB_LOCKED} lock_e;
   lock_e           lock_q, lock_d;
   logic [CH_W-1:0] lock_ch_q, lock_ch_d;
   logic            out_last_q, out_last_d;
`endif

   logic [W-1:0]    ch_data [N_CH];
   logic            scan_found;
   logic [CH_W-1:0] scan_g;
   logic            found;
   logic [CH_W-1:0] g;
   logic [CH_W-1:0] g_next;
   logic [N_CH-1:0] gnt;
   logic            load_en;
   logic            xfer;

   for (genvar i = 0; i < N_CH; i++) begin : g_unpack
      assign ch_data[i] = bus.in_data[i*W +: W];
   end

   // Rotating priority scan. Walking offsets from high to low leaves the
   // valid channel closest to ptr as the final winner.
   always_comb begin
      logic [CH_W:0]   sum;
      logic [CH_W-1:0] idx;
      // NOTE: every always_comb output gets a default before any branch, so no path infers a latch.
      scan_found = 1'b0;
      scan_g     = '0;
      sum        = '0;
      idx        = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         sum = {1'b0, ptr_q} + (CH_W + 1)'(k);
         if (sum >= (CH_W + 1)'(N_CH)) begin
            sum = sum - (CH_W + 1)'(N_CH);
         end
         idx = sum[CH_W-1:0];
         if (bus.in_valid[idx]) begin
            scan_found = 1'b1;
            scan_g     = idx;
         end
      end
   end

`ifdef STREAM_MUX_PKT_LOCK_EN
   // A packet in flight owns the arbiter regardless of the other requests.
   always_comb begin
      found = scan_found;
      g     = scan_g;
      if (lock_q == ARB_LOCKED) begin
         found = bus.in_valid[lock_ch_q];
         g     = lock_ch_q;
      end
   end
`else
   assign found = scan_found;
   assign g     = scan_g;
`endif

   always_comb begin
      gnt    = '0;
      gnt[g] = found;
   end

   assign g_next  = (g == CH_W'(N_CH - 1)) ? '0 : g + 1'b1;
   assign load_en = !out_valid_q || bus.out_ready;
   // Gating with rst_n keeps any handshake from completing while reset is held.
   assign bus.in_ready = gnt & {N_CH{load_en & rst_n}};
   assign xfer         = found && load_en;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_d      = lock_q;
      lock_ch_d   = lock_ch_q;
      out_last_d  = out_last_q;
`endif
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = ch_data[g];
         out_ch_d    = g;
`ifdef STREAM_MUX_PKT_LOCK_EN
         out_last_d  = bus.in_last[g];
         if (bus.in_last[g]) begin
            lock_d = ARB_FREE;
            ptr_d  = g_next;
         end else begin
            lock_d    = ARB_LOCKED;
            lock_ch_d = g;
         end
`else
         ptr_d = g_next;
`endif
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
         lock_q      <= ARB_FREE;
         lock_ch_q   <= '0;
         out_last_q  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
         lock_q      <= lock_d;
         lock_ch_q   <= lock_ch_d;
         out_last_q  <= out_last_d;
`endif
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
   assign bus.out_last  = out_last_q;
`endif

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(bus.in_ready));

   a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
      bus.out_valid && !bus.out_ready |=>
         bus.out_valid && $stable(bus.out_data) && $stable(bus.out_ch));
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit stream multiplexer; successor to the 2:1 bit-level mux.
- Selection is by a round-robin arbiter, not a select input.
- Per-channel valid/ready handshake; one registered output stage.
- Used wherever several producers in the npc datapath share one consumer, e.g. request merge toward a memory or trace port.

Parameters:
- N_CH, 4: number of input channels; must be ≥2; non-power-of-two values are legal.
- W, 8: data width per channel in bits; must be ≥1.
- CH_W, $clog2(N_CH): localparam, width of the channel index.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  N_CH  per-channel valid; bit i belongs to channel i
- in_data  in  N_CH*W  packed data; channel i occupies bits [i*W +: W]
- in_ready  out  N_CH  per-channel ready; combinational
- out_valid  out  1  output register holds a beat
- out_data  out  W  registered data
- out_ch  out  CH_W  index of the source channel of out_data
- out_ready  in  1  downstream accepts the beat

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0, so channel 0 has first priority.
  - Reset mid-transfer discards the held beat; no handshake completes in that cycle.
- load_en = !out_valid || out_ready. The output register accepts a new beat when empty or when its current beat is being consumed in the same cycle.
- Arbitration (combinational):
  - Scan channels ptr, ptr+1, … wrapping mod N_CH.
  - The first channel with in_valid=1 is granted (gnt, one-hot, plus index g).
  - No request: gnt=0.
- in_ready[i] = gnt[i] && load_en. At most one bit of in_ready is high. in_ready may depend on in_valid; producers must not make in_valid depend on in_ready.
- Transfer on channel g when in_valid[g] && in_ready[g]. Next edge:
  - out_valid=1, out_data=in_data[g], out_ch=g.
  - ptr = (g==N_CH-1) ? 0 : g+1.
- Output consumed (out_valid && out_ready) with no new transfer: out_valid→0; out_data/out_ch keep their old values.
- out_valid && !out_ready: out_valid, out_data and out_ch hold stable; every in_ready=0; ptr unchanged.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: one beat per cycle when out_ready is held 1.
- ptr advances only on a completed input transfer, never on idle cycles.
- Fairness: with all channels continuously valid and out_ready=1, the grant order is 0,1,…,N_CH-1,0,…
- Input producers hold in_valid and in_data until their handshake completes; the block does not buffer ungranted data.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN
- Defined:
  - Extra input port in_last, N_CH bits.
  - Once channel g completes a transfer with in_last[g]=0, the arbiter is locked to g. Only g may be granted, even if other channels are valid, until a transfer of g with in_last[g]=1.
  - On that last beat: lock released, ptr = g+1 mod N_CH.
  - While locked, ptr does not advance.
  - Lock state resets to unlocked.
  - Extra output out_last (registered alongside out_data; reset 0).
- Undefined:
  - No in_last/out_last ports.
  - Every beat is arbitrated independently as above.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with out_valid=1 → out_valid=0, out_ch=0, all in_ready=0 immediately; after release, first grant goes to channel 0 when all are valid.
- Single channel: N_CH=4, W=8, only ch2 valid with data 0x11,0x22,0x33 and out_ready=1 → out_data 0x11,0x22,0x33 on consecutive cycles, out_ch=2, 1-cycle latency.
- Full contention: all 4 channels valid continuously (ch i data = 0xA0+i), out_ready=1 → out_ch sequence 0,1,2,3,0,1; out_data matches.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → out_data/out_ch stable, all in_ready=0, ptr unchanged; on out_ready=1 the next channel in rotation is delivered with no bubble.
- Wrap with N_CH=3: only ch2 and ch0 valid → grant order 0,2,0,2; ch1 never granted; ptr wraps 2→0.
- With STREAM_MUX_PKT_LOCK_EN: ch1 sends 3 beats with in_last on beat 3, ch0 and ch2 also valid → output is ch1,ch1,ch1 then ch2; out_last=1 only on the third beat.
